prf_read_arbiter: RTL
=====================

Name: prf_read_arbiter

Overview:
- Shares the four single-read-port PRF banks among the 11 PRF read requesters (IQ issue ports).
- Each cycle, arbitrates per bank by round-robin and issues a registered bank read command.
- Tracks each granted read through the 1-cycle bank access and asserts a per-requester response-valid pulse.
- Sits between the issue queues and the PRF bank array.

Parameters:
- PRF_RR_COUNT, 11, number of read requesters.
- PRF_BANK_COUNT, 4, number of PRF banks, one read port each.
- LOG_PRF_BANK_COUNT, 2, bank select width.
- LOG_PR_COUNT, 7, physical register index width.
- LOG_RR_COUNT, 4, requester index width, $clog2(PRF_RR_COUNT).

Ports:
- CLK  in  1  clock.
- nRST  in  1  synchronous active-low reset.
- req_valid_by_rr  in  PRF_RR_COUNT  requester holds read request.
- req_PR_by_rr  in  PRF_RR_COUNT x LOG_PR_COUNT  requested physical register.
- req_ready_by_rr  out  PRF_RR_COUNT  combinational grant this cycle.
- bank_stall_by_bank  in  PRF_BANK_COUNT  bank port unavailable this cycle.
- bank_read_valid_by_bank  out  PRF_BANK_COUNT  registered bank read enable.
- bank_read_upper_PR_by_bank  out  PRF_BANK_COUNT x (LOG_PR_COUNT-LOG_PRF_BANK_COUNT)  row index PR[6:2].
- bank_read_rr_by_bank  out  PRF_BANK_COUNT x LOG_RR_COUNT  winning requester index.
- resp_valid_by_rr  out  PRF_RR_COUNT  read data for requester valid this cycle.
- resp_bank_by_rr  out  PRF_RR_COUNT x LOG_PRF_BANK_COUNT  bank carrying that requester's data.

Behaviour:
- Bank of a request is PR[1:0]; row is PR[6:2].
- Handshake: requester asserts valid with a stable PR until it sees ready high in the same cycle. Ready may depend on valid. Ready is never high without valid.
- Arbitration, per bank b:
  - Eligible requesters are those with valid and PR[1:0]==b.
  - The winner is the first eligible index scanning from rr_ptr[b] upward, wrapping 10->0.
  - At most one grant per bank per cycle; at most one grant per requester per cycle.
- If bank_stall_by_bank[b]=1: no grant for bank b, rr_ptr[b] holds, and bank_read_valid[b] is 0 next cycle.
- Pointer update: on a grant to index w, rr_ptr[b] <= (w==10) ? 0 : w+1. With no grant, the pointer holds.
- Stage 1, at the edge after the grant:
  - bank_read_valid[b]=1; bank_read_upper_PR[b] and bank_read_rr[b] are set to the winner's values.
  - With no grant, valid=0 and the other fields hold their previous values.
- Stage 2, at the edge after stage 1: for each stage-1-valid bank b, resp_valid_by_rr[bank_read_rr[b]]=1 and resp_bank_by_rr[that rr]=b. All other resp_valid bits are 0.
- Latency is grant at cycle N, bank read at N+1, response at N+2, fully pipelined. Back-to-back grants to the same requester are allowed.
- Reset (nRST=0 at an edge):
  - rr_ptr all 0.
  - All bank_read_* outputs and all resp_* outputs become 0.
  - In-flight stage 1/2 entries are discarded.
  - req_ready is forced 0 while nRST=0.
- Non-power-of-2 wrap: pointer values 11..15 are unreachable. If encountered, treat as 0.
- Four requesters to four distinct banks: all granted the same cycle.

Optional Feature:
- Macro PRF_READ_ARBITER_PERF_EN.
- When defined, adds output conflict_count_by_bank (PRF_BANK_COUNT x 16).
  - Per-bank saturating counter, +1 each cycle where bank b has one or more eligible requesters that were not granted (losers or stall).
  - Saturates at 16'hFFFF. Reset to 0.
- When undefined, the port and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then rr0 PR=7'h05 -> ready[0]=1 at N; bank_read_valid[1]=1, upper_PR=1, rr=0 at N+1; resp_valid[0]=1, resp_bank[0]=1 at N+2.
- rr2, rr5, rr9 all PR bank 0, held valid -> grants in order 2,5,9 over 3 cycles; rr_ptr[0]=10 afterwards; next conflict between rr0 and rr9 grants rr0 (wrap).
- rr0..rr3 with PR=0,1,2,3 -> all four ready the same cycle; four bank reads at N+1; resp_valid=4'b1111 on low bits at N+2.
- bank_stall[2]=1 for 3 cycles with rr4 PR=7'h0A -> ready[4]=0 for 3 cycles, granted on cycle 4; rr_ptr[2] unchanged during the stall.
- nRST=0 one cycle after a grant -> no resp_valid pulse; all outputs 0; next grant starts from rr_ptr=0.
- PERF_EN: rr1 and rr6 both on bank 3 for 4 cycles, both re-requesting after each grant -> conflict_count[3]=4.

Source files
------------

// File: rtl/prf_read_arbiter.sv
// Per-bank round-robin arbiter that shares four single-read-port PRF banks among 11 requesters.
// A grant is followed by a registered bank read and then a response pulse. Define PRF_READ_ARBITER_PERF_EN to add per-bank conflict counters.
module prf_read_arbiter #(
    parameter int PRF_RR_COUNT       = 11,
    parameter int PRF_BANK_COUNT     = 4,
    parameter int LOG_PRF_BANK_COUNT = 2,
    parameter int LOG_PR_COUNT       = 7,
    parameter int LOG_RR_COUNT       = 4
) (
    input  logic                                                           CLK,
    input  logic                                                           nRST,
    input  logic [PRF_RR_COUNT-1:0]                                        req_valid_by_rr,
    input  logic [PRF_RR_COUNT-1:0][LOG_PR_COUNT-1:0]                      req_PR_by_rr,
    output logic [PRF_RR_COUNT-1:0]                                        req_ready_by_rr,
    input  logic [PRF_BANK_COUNT-1:0]                                      bank_stall_by_bank,
    output logic [PRF_BANK_COUNT-1:0]                                      bank_read_valid_by_bank,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] bank_read_upper_PR_by_bank,
    output logic [PRF_BANK_COUNT-1:0][LOG_RR_COUNT-1:0]                    bank_read_rr_by_bank,
`ifdef PRF_READ_ARBITER_PERF_EN
    output logic [PRF_BANK_COUNT-1:0][15:0]                                conflict_count_by_bank,
`endif
    output logic [PRF_RR_COUNT-1:0]                                        resp_valid_by_rr,
    output logic [PRF_RR_COUNT-1:0][LOG_PRF_BANK_COUNT-1:0]                resp_bank_by_rr
);

    localparam int UPPER_W = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

    typedef logic [LOG_RR_COUNT-1:0] rr_idx_t;
    typedef logic [UPPER_W-1:0]      upper_t;

    logic    [PRF_BANK_COUNT-1:0][PRF_RR_COUNT-1:0] eligible_by_bank;
    logic    [PRF_BANK_COUNT-1:0]                   grant_valid_by_bank;
    rr_idx_t [PRF_BANK_COUNT-1:0]                   grant_rr_by_bank;

    rr_idx_t [PRF_BANK_COUNT-1:0] rr_ptr_q, rr_ptr_d;
    logic    [PRF_BANK_COUNT-1:0] bank_read_valid_q, bank_read_valid_d;
    upper_t  [PRF_BANK_COUNT-1:0] bank_read_upper_q, bank_read_upper_d;
    rr_idx_t [PRF_BANK_COUNT-1:0] bank_read_rr_q, bank_read_rr_d;

    logic [PRF_RR_COUNT-1:0]                         resp_valid_q, resp_valid_d;
    logic [PRF_RR_COUNT-1:0][LOG_PRF_BANK_COUNT-1:0] resp_bank_q, resp_bank_d;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        eligible_by_bank = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            for (int r = 0; r < PRF_RR_COUNT; r++) begin
                eligible_by_bank[b][r] = req_valid_by_rr[r] &&
                    (req_PR_by_rr[r][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
            end
        end
    end

    // Scan from the pointer upward with wrap; out-of-range pointer values restart at 0.
    always_comb begin
        int start_idx;
        int idx;
        grant_valid_by_bank = '0;
        grant_rr_by_bank    = '0;
        start_idx           = 0;
        idx                 = 0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            start_idx = (int'(rr_ptr_q[b]) >= PRF_RR_COUNT) ? 0 : int'(rr_ptr_q[b]);
            for (int i = 0; i < PRF_RR_COUNT; i++) begin
                idx = start_idx + i;
                if (idx >= PRF_RR_COUNT) idx = idx - PRF_RR_COUNT;
                if (nRST && !bank_stall_by_bank[b] && !grant_valid_by_bank[b] && eligible_by_bank[b][idx]) begin
                    grant_valid_by_bank[b] = 1'b1;
                    grant_rr_by_bank[b]    = rr_idx_t'(idx);
                end
            end
        end
    end

    // A requester maps to exactly one bank, so it can win at most once per cycle.
    always_comb begin
        req_ready_by_rr = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            if (grant_valid_by_bank[b]) req_ready_by_rr[grant_rr_by_bank[b]] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d          = rr_ptr_q;
        bank_read_valid_d = grant_valid_by_bank;
        bank_read_upper_d = bank_read_upper_q;
        bank_read_rr_d    = bank_read_rr_q;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            if (grant_valid_by_bank[b]) begin
                rr_ptr_d[b] = (grant_rr_by_bank[b] == rr_idx_t'(PRF_RR_COUNT - 1)) ?
                              '0 : grant_rr_by_bank[b] + rr_idx_t'(1);
                bank_read_upper_d[b] = req_PR_by_rr[grant_rr_by_bank[b]][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
                bank_read_rr_d[b]    = grant_rr_by_bank[b];
            end
        end
    end

    always_comb begin
        resp_valid_d = '0;
        resp_bank_d  = resp_bank_q;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            if (bank_read_valid_q[b]) begin
                resp_valid_d[bank_read_rr_q[b]] = 1'b1;
                resp_bank_d[bank_read_rr_q[b]]  = LOG_PRF_BANK_COUNT'(b);
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rr_ptr_q          <= '0;
            bank_read_valid_q <= '0;
            bank_read_upper_q <= '0;
            bank_read_rr_q    <= '0;
            resp_valid_q      <= '0;
            resp_bank_q       <= '0;
        end else begin
            rr_ptr_q          <= rr_ptr_d;
            bank_read_valid_q <= bank_read_valid_d;
            bank_read_upper_q <= bank_read_upper_d;
            bank_read_rr_q    <= bank_read_rr_d;
            resp_valid_q      <= resp_valid_d;
            resp_bank_q       <= resp_bank_d;
        end
    end

    assign bank_read_valid_by_bank    = bank_read_valid_q;
    assign bank_read_upper_PR_by_bank = bank_read_upper_q;
    assign bank_read_rr_by_bank       = bank_read_rr_q;
    assign resp_valid_by_rr           = resp_valid_q;
    assign resp_bank_by_rr            = resp_bank_q;

`ifdef PRF_READ_ARBITER_PERF_EN
    logic [PRF_BANK_COUNT-1:0][15:0] conflict_count_q, conflict_count_d;

    // A cycle counts when any eligible requester on the bank leaves without a grant.
    always_comb begin
        conflict_count_d = conflict_count_q;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            if ((|(eligible_by_bank[b] & ~req_ready_by_rr)) && (conflict_count_q[b] != 16'hFFFF))
                conflict_count_d[b] = conflict_count_q[b] + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) conflict_count_q <= '0;
        else       conflict_count_q <= conflict_count_d;
    end

    assign conflict_count_by_bank = conflict_count_q;
`endif

endmodule
